// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// ctl_t bundles every per-cycle control output so each state can assign it as one value.
package hazard_pkg;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 16;
  localparam int DCNT_W       = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic halted;
  } ctl_t;

  localparam ctl_t CTL_RUN   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctl_t CTL_FRZ   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctl_t CTL_DRAIN = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctl_t CTL_HALT  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctl_t CTL_RST   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module sat_counter
  import hazard_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                 count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, branch flush, memory freeze and
// drain-to-halt sequencing, plus saturating stall/flush performance counters.
module hazard_controller
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             IFID_use_rs1,
  input  logic             IFID_use_rs2,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEXrd,
  input  logic             EX_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e            state, state_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;
  ctl_t              ctl;
  logic              mem_stall, load_use;
  logic              stall_inc, flush_inc;

  assign mem_stall = mem_req & ~mem_ack;
  assign load_use  = IDEX_MemRead && (IDEXrd != 5'd0) &&
                     ((IFID_use_rs1 && (IDEXrd == IFID_rs1)) ||
                      (IFID_use_rs2 && (IDEXrd == IFID_rs2)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    ctl       = CTL_RUN;
    state_nxt = state;
    dcnt_nxt  = dcnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          ctl       = CTL_FRZ;
          state_nxt = MEM_WAIT;
        end else begin
          // Branch wins over load-use: the dependent instruction is squashed anyway.
          if (EX_branch_taken) begin
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
          end else if (load_use) begin
            ctl.pc_en      = 1'b0;
            ctl.ifid_en    = 1'b0;
            ctl.idex_flush = 1'b1;
          end
          if (halt_req) begin
            state_nxt = DRAIN;
            dcnt_nxt  = DCNT_W'(DRAIN_CYCLES);
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          // Ack releases the pipe this cycle; a pending branch flush lands here.
          if (EX_branch_taken) begin
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
          end
          state_nxt = RUN;
        end else begin
          ctl = CTL_FRZ;
        end
      end
      DRAIN: begin
        if (mem_stall) begin
          ctl = CTL_FRZ;
        end else begin
          ctl      = CTL_DRAIN;
          dcnt_nxt = dcnt - 1'b1;
          if (dcnt == DCNT_W'(1)) state_nxt = HALTED;
        end
      end
      HALTED: begin
        ctl = CTL_HALT;
        if (resume) state_nxt = RUN;
      end
      default: begin
        ctl       = CTL_FRZ;
        state_nxt = RUN;
      end
    endcase
    if (!rst) ctl = CTL_RST;
  end

  assign pc_en      = ctl.pc_en;
  assign ifid_en    = ctl.ifid_en;
  assign exmem_en   = ctl.exmem_en;
  assign memwb_en   = ctl.memwb_en;
  assign ifid_flush = ctl.ifid_flush;
  assign idex_flush = ctl.idex_flush;
  assign halted     = ctl.halted;

  // A parked pipe in HALTED is not a stall.
  assign stall_inc = rst && !ctl.pc_en && (state != HALTED);
  assign flush_inc = rst && ctl.ifid_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: expected control vectors are queued as
// each cycle's stimulus is driven and popped when outputs are sampled on the falling edge.
module tb_hazard_controller;
  import hazard_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [4:0]       IFID_rs1, IFID_rs2, IDEXrd;
  logic             IFID_use_rs1, IFID_use_rs2, IDEX_MemRead;
  logic             EX_branch_taken, mem_req, mem_ack, halt_req, resume;
  logic             pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic       mreq;
    logic       mack;
    logic       hr;
    logic       res;
  } stim_t;

  // {pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted}
  localparam logic [6:0] E_RUN = 7'b1111_00_0;
  localparam logic [6:0] E_LU  = 7'b0011_01_0;
  localparam logic [6:0] E_BR  = 7'b1111_11_0;
  localparam logic [6:0] E_FRZ = 7'b0000_00_0;
  localparam logic [6:0] E_DRN = 7'b0011_01_0;
  localparam logic [6:0] E_HLT = 7'b0000_00_1;
  localparam logic [6:0] E_RST = 7'b0000_11_0;

  logic [6:0] exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  stim_t      s;

  hazard_controller dut (
    .clk             (clk),
    .rst             (rst),
    .IFID_rs1        (IFID_rs1),
    .IFID_rs2        (IFID_rs2),
    .IFID_use_rs1    (IFID_use_rs1),
    .IFID_use_rs2    (IFID_use_rs2),
    .IDEX_MemRead    (IDEX_MemRead),
    .IDEXrd          (IDEXrd),
    .EX_branch_taken (EX_branch_taken),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input stim_t t);
    IDEX_MemRead    = t.mr;
    IDEXrd          = t.rd;
    IFID_rs1        = t.rs1;
    IFID_rs2        = t.rs2;
    IFID_use_rs1    = t.u1;
    IFID_use_rs2    = t.u2;
    EX_branch_taken = t.br;
    mem_req         = t.mreq;
    mem_ack         = t.mack;
    halt_req        = t.hr;
    resume          = t.res;
  endtask

  task automatic sample(input string tag);
    logic [6:0] got;
    got = {pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};
    if (exp_q.size() == 0) chk({tag, "_empty_q"}, 32'd1, 32'd0);
    else                   chk(tag, {25'd0, got}, {25'd0, exp_q.pop_front()});
  endtask

  task automatic step(input string tag, input stim_t t, input logic [6:0] exp);
    @(posedge clk);
    #1 apply(t);
    exp_q.push_back(exp);
    @(negedge clk);
    sample(tag);
  endtask

  task automatic cnt_chk(input string tag, input int st, input int fl);
    chk({tag, "_stall"}, {16'd0, stall_cnt}, st);
    chk({tag, "_flush"}, {16'd0, flush_cnt}, fl);
  endtask

  // Reset asserted between clock edges; t is what the inputs show while reset is low.
  task automatic mid_reset(input string tag, input stim_t t);
    @(posedge clk);
    #3 rst = 1'b0;
    apply(t);
    exp_q.push_back(E_RST);
    @(negedge clk);
    sample(tag);
    cnt_chk(tag, 0, 0);
    #1 apply('0);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s = '0;
    apply(s);
    exp_q.push_back(E_RST);
    @(negedge clk);
    sample("por");
    cnt_chk("por", 0, 0);
    #1 rst = 1'b1;

    // load-use detection
    s = '0;                                  step("run_idle", s, E_RUN);
    s.mr = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1; step("lu_rs2", s, E_LU);
    s.u2 = 0;                                step("lu_rs2_unused", s, E_RUN);
    cnt_chk("lu_one", 1, 0);
    s = '0; s.mr = 1; s.rd = 7; s.rs1 = 7; s.u1 = 1; step("lu_rs1", s, E_LU);
    s.mr = 0;                                step("no_load", s, E_RUN);
    s = '0; s.mr = 1; s.u1 = 1; s.u2 = 1;    step("x0", s, E_RUN);
    s = '0;                                  step("idle_a", s, E_RUN);
    cnt_chk("lu_done", 2, 0);

    // branch overrides load-use
    mid_reset("rst_b", '0);
    s = '0; s.br = 1; s.mr = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1; step("br_lu", s, E_BR);
    s = '0;                                  step("idle_b", s, E_RUN);
    cnt_chk("br_lu", 0, 1);

    // memory wait, then same-cycle req/ack, then branch held off by the wait
    mid_reset("rst_c", '0);
    s = '0; s.mreq = 1;
    for (int i = 0; i < 4; i++) step("mw_frz", s, E_FRZ);
    s.mack = 1;                              step("mw_ack", s, E_RUN);
    cnt_chk("mw", 4, 0);
                                             step("mw_same", s, E_RUN);
    s = '0; s.mreq = 1; s.br = 1;            step("mwb_frz0", s, E_FRZ);
                                             step("mwb_frz1", s, E_FRZ);
    s.mack = 1;                              step("mwb_ack", s, E_BR);
    s = '0;                                  step("idle_c", s, E_RUN);
    cnt_chk("mwb", 6, 1);

    // plain halt / resume
    mid_reset("rst_d", '0);
    s = '0; s.hr = 1;                        step("halt_req", s, E_RUN);
    s = '0;
    for (int i = 0; i < 3; i++) step("drain", s, E_DRN);
                                             step("halted", s, E_HLT);
    s.hr = 1;                                step("halt_ign", s, E_HLT);
    s = '0; s.res = 1;                       step("resume", s, E_HLT);
    s = '0;                                  step("run_again", s, E_RUN);
    cnt_chk("halt", 3, 0);

    // halt with branch and a 2-cycle memory stall inside DRAIN
    mid_reset("rst_e", '0);
    s = '0; s.hr = 1; s.br = 1;              step("halt_br", s, E_BR);
    s = '0;                                  step("dm_drn0", s, E_DRN);
    s.mreq = 1;                              step("dm_frz0", s, E_FRZ);
                                             step("dm_frz1", s, E_FRZ);
    s = '0;                                  step("dm_drn1", s, E_DRN);
                                             step("dm_drn2", s, E_DRN);
                                             step("dm_halted", s, E_HLT);
    s.res = 1;                               step("dm_resume", s, E_HLT);
    s = '0;                                  step("dm_run", s, E_RUN);
    cnt_chk("dm", 5, 1);

    // reset mid-DRAIN and mid-MEM_WAIT abandon the operation
    s = '0; s.hr = 1;                        step("rd_halt", s, E_RUN);
    s = '0;                                  step("rd_drn0", s, E_DRN);
                                             step("rd_drn1", s, E_DRN);
    s = '0; s.hr = 1; s.mreq = 1;
    mid_reset("rst_drain", s);
    s = '0;                                  step("rd_post", s, E_RUN);
    s.mreq = 1;                              step("rm_frz0", s, E_FRZ);
                                             step("rm_frz1", s, E_FRZ);
    mid_reset("rst_memwait", s);
    s = '0;                                  step("rm_post", s, E_RUN);

    // saturation: 65534 frozen cycles reach FFFE, three more must stop at FFFF
    mid_reset("rst_g", '0);
    s = '0; s.mreq = 1;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
      #1 apply(s);
    end
    s.mack = 1;                              step("sat_ack0", s, E_RUN);
    cnt_chk("sat_pre", 16'hFFFE, 0);
    s.mack = 0;
    for (int i = 0; i < 3; i++) step("sat_frz", s, E_FRZ);
    s.mack = 1;                              step("sat_ack1", s, E_RUN);
    cnt_chk("sat", 16'hFFFF, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
